// File: rtl/fp_panel_ctrl_pkg.sv
// rtl/fp_panel_ctrl_pkg.sv - shared constants and helpers for the SAP front-panel controller
// Contents: FSM state encodings, keypad digit width, default bus widths,
//           and the saturating digit-counter increment.
package fp_panel_ctrl_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int KEY_W      = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EXAM  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  function automatic logic [2:0] sat_inc3(input logic [2:0] cnt, input logic [2:0] lim);
    return (cnt >= lim) ? cnt : cnt + 3'd1;
  endfunction

endpackage

// File: rtl/fp_panel_ctrl_nibble_entry.sv
// rtl/fp_panel_ctrl_nibble_entry.sv - hex-digit shift register with saturating digit count
// Ports: CLOCK_100MHZ/CLR clock and async reset; load_i/load_data_i parallel load
//        (clears count); shift_i/key_i shift in one hex digit; data_o, nib_cnt_o state.
module fp_panel_ctrl_nibble_entry
  import fp_panel_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              CLOCK_100MHZ,
  input  logic              CLR,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              shift_i,
  input  logic [KEY_W-1:0]  key_i,
  output logic [DATA_W-1:0] data_o,
  output logic [2:0]        nib_cnt_o
);

  localparam logic [2:0] NIB = 3'(DATA_W / 4);

  logic [DATA_W-1:0] data_q, data_d, shifted;
  logic [2:0]        cnt_q, cnt_d;

  // A single-digit-wide register simply takes the new key.
  generate
    if (DATA_W > 4) begin : g_wide
      assign shifted = {data_q[DATA_W-5:0], key_i};
    end else begin : g_narrow
      assign shifted = key_i;
    end
  endgenerate

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      data_d = load_data_i;
      cnt_d  = 3'd0;
    end else if (shift_i) begin
      data_d = shifted;
      cnt_d  = sat_inc3(cnt_q, NIB);
    end
  end

  always_ff @(posedge CLOCK_100MHZ or posedge CLR) begin
    if (CLR) begin
      data_q <= '0;
      cnt_q  <= 3'd0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o    = data_q;
  assign nib_cnt_o = cnt_q;

endmodule

// File: rtl/fp_panel_ctrl.sv
// rtl/fp_panel_ctrl.sv - SAP front-panel controller: examine/deposit, stepping, run latch, clock gating
// Ports: panel pulses (next/prev/deposit/key) and levels (manual/prog) in; bus_in read data;
//        fp_adr/fp_data/fp_write memory side; nib_cnt digit count; run latch and core clock enables.
module fp_panel_ctrl
  import fp_panel_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RD_LAT    = 1,
  parameter int WR_CYCLES = 1,
  parameter int AUTO_INC  = 1
) (
  input  logic              CLOCK_100MHZ,
  input  logic              CLR,
  input  logic              tick_auto,
  input  logic              tick_auto_oop,
  input  logic              step_rise,
  input  logic              step_fall,
  input  logic              manual,
  input  logic              prog,
  input  logic              next_pulse,
  input  logic              prev_pulse,
  input  logic              deposit_pulse,
  input  logic              key_valid,
  input  logic [KEY_W-1:0]  key_code,
  input  logic [ADDR_W-1:0] adr_init,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              halt,
  output logic [ADDR_W-1:0] fp_adr,
  output logic [DATA_W-1:0] fp_data,
  output logic              fp_write,
  output logic [2:0]        nib_cnt,
  output logic              run,
  output logic              core_clken,
  output logic              core_clken_oop
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int WR_W  = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);
  localparam logic [WR_W-1:0]  WR_LAST  = WR_W'(WR_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [WR_W-1:0]   wr_q, wr_d;
  logic              write_q, write_d;
  logic              run_q;
  logic              load, shift;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    lat_d   = lat_q;
    wr_d    = wr_q;
    write_d = write_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Any address key outranks deposit/key; pressing both cancels out.
        if (next_pulse | prev_pulse) begin
          if (next_pulse ^ prev_pulse) begin
            adr_d   = next_pulse ? adr_q + ADDR_W'(1) : adr_q - ADDR_W'(1);
            lat_d   = '0;
            state_d = ST_EXAM;
          end
        end else if (deposit_pulse & prog) begin
          // Strobe is registered so it rises the cycle after the press.
          write_d = 1'b1;
          wr_d    = '0;
          state_d = ST_WRITE;
        end else if (key_valid) begin
          shift = 1'b1;
        end
      end
      ST_EXAM: begin
        if (lat_q == LAT_LAST) begin
          load    = 1'b1;
          lat_d   = '0;
          state_d = ST_IDLE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ST_WRITE: begin
        if (wr_q == WR_LAST) begin
          // Address only moves once the strobe is gone, keeping the write target stable.
          write_d = 1'b0;
          wr_d    = '0;
          if (AUTO_INC != 0) begin
            adr_d   = adr_q + ADDR_W'(1);
            lat_d   = '0;
            state_d = ST_EXAM;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          wr_d = wr_q + WR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_100MHZ or posedge CLR) begin
    if (CLR) begin
      state_q <= ST_EXAM;
      adr_q   <= adr_init;
      lat_q   <= '0;
      wr_q    <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      lat_q   <= lat_d;
      wr_q    <= wr_d;
      write_q <= write_d;
    end
  end

  // Halt is sticky: only CLR restarts the core.
  always_ff @(posedge CLOCK_100MHZ or posedge CLR) begin
    if (CLR) begin
      run_q <= 1'b1;
    end else if (halt) begin
      run_q <= 1'b0;
    end
  end

  fp_panel_ctrl_nibble_entry #(
    .DATA_W (DATA_W)
  ) u_nibble (
    .CLOCK_100MHZ (CLOCK_100MHZ),
    .CLR          (CLR),
    .load_i       (load),
    .load_data_i  (bus_in),
    .shift_i      (shift),
    .key_i        (key_code),
    .data_o       (fp_data),
    .nib_cnt_o    (nib_cnt)
  );

  assign fp_adr         = adr_q;
  assign fp_write       = write_q;
  assign run            = run_q;
  assign core_clken     = run_q & ~prog & (manual ? step_rise : tick_auto);
  assign core_clken_oop = run_q & ~prog & (manual ? step_fall : tick_auto_oop);

endmodule
